sample_to_wr_req: RTL and testbench
===================================

// Module: sample_to_wr_req
// PURPOSE
//  Upstream write-request source for fifo_to_app. Packs 32-bit capture samples into 128-bit
//  DDR2 words (one 2-beat 64-bit app burst each), tags each with an incrementing byte address,
//  and buffers word+address pairs in a first-word-fall-through FIFO.
//  Presents them on the has_wr_req/get_wr_req handshake consumed by fifo_to_app.
// PARAMETERS
//  SAMPLE_W    32           sample width; 128/SAMPLE_W = 4 samples per word (fixed ratio)
//  DEPTH_LOG2  4            FIFO depth = 2**DEPTH_LOG2 = 16 entries
//  ADX_BASE    27'h0000000  first write address
//  ADX_END     27'h7FFFFF0  last write address; next address after it is ADX_BASE
//  ADX_STEP    27'd16       address increment per 128-bit word (bytes)
// PORTS
//  clk           in   1    system clock
//  resetn        in   1    reset
//  flush         in   1    synchronous clear of packer, FIFO, address, flags
//  sample_valid  in   1    sample_data valid this cycle
//  sample_data   in   32   capture sample
//  has_wr_req    out  1    FIFO head valid
//  get_wr_req    in   1    pop strobe from fifo_to_app
//  wr_data_out   out  128  head data (to fifo_to_app wr_data_in)
//  wr_adx_out    out  27   head address (to fifo_to_app wr_adx_in)
//  fifo_count    out  5    entries held, 0..16
//  overflow      out  1    sticky: a completed word was dropped because the FIFO was full
//  wrapped       out  1    one-cycle pulse when the address counter wraps ADX_END->ADX_BASE
// BEHAVIOUR
//  Reset is resetn: synchronous, active-low; clock is clk.
//  Reset / flush values:
//   - FIFO empty, so has_wr_req=0 and fifo_count=0.
//   - wr_data_out=0, wr_adx_out=0, overflow=0, wrapped=0.
//   - Packer lane index=0; address counter=ADX_BASE.
//  Priority: resetn low > flush high > normal operation. Both discard partial words and all
//   FIFO content. sample_valid and get_wr_req are ignored in that cycle.
//  Packer:
//   - Lane counter 0..3. Sample k of a word goes to bits [32k+31:32k], so the first sample is
//     in [31:0].
//   - Lane advances only when sample_valid=1. No timeout: a partial word waits indefinitely.
//  Push:
//   - The 4th sample in cycle N loads {word, addr} into the FIFO at the edge ending cycle N.
//   - If the FIFO was empty, has_wr_req=1 in cycle N+1 (latency 1).
//   - Pushed entry carries the current address counter; the counter then steps by ADX_STEP.
//  Address wrap: when the pushed address == ADX_END, the counter loads ADX_BASE and wrapped=1
//   for exactly cycle N+1. Arithmetic is 27-bit unsigned; no carry beyond bit 26.
//  Pop / FWFT:
//   - wr_data_out and wr_adx_out always reflect the head entry when has_wr_req=1; they are
//     don't-care when has_wr_req=0.
//   - get_wr_req=1 with has_wr_req=1 removes the head; the next entry appears the following
//     cycle.
//   - get_wr_req with the FIFO empty is ignored: no underflow, count stays 0.
//  Full:
//   - A push when fifo_count=16 and no pop this cycle drops the word.
//   - On a drop the address does not advance and overflow is set. overflow clears only on
//     reset or flush.
//   - A push and pop in the same cycle when full both succeed; count stays 16.
//  Simultaneous push+pop at any count: count unchanged, order preserved.
//  Pop+push on an empty FIFO cannot occur, because has_wr_req=0 makes the pop a no-op.
//  fifo_count is registered and equals the FIFO occupancy after each edge.
//  Implementation: FIFO storage is 16 x 155 bits (128 data + 27 address) with DEPTH_LOG2+1
//   bit pointers; full/empty come from the MSB comparison.
// TESTING
//  T1 reset: hold resetn=0 for 4 clk with sample_valid=1 -> has_wr_req=0, fifo_count=0,
//   overflow=0 throughout.
//  T2 pack: samples 1,2,3,4 on consecutive cycles ->
//   - next cycle has_wr_req=1, wr_data_out=128'h00000004_00000003_00000002_00000001,
//     wr_adx_out=0.
//   - Second group of 4 -> entry with wr_adx_out=16.
//  T3 backpressure: get_wr_req=0, push 17 words ->
//   - fifo_count=16, overflow=1.
//   - Popping all 16 gives addresses 0..240 in order; the dropped 17th word is absent.
//   - The next push uses address 256.
//  T4 wrap: ADX_END=27'h30, push 5 words -> addresses 0,16,32,48,0; wrapped pulses 1 cycle
//   after the 4th push.
//  T5 mid-op flush: 2 samples then flush, then 4 samples -> a single entry with addr=ADX_BASE
//   holding only the post-flush samples.
//  T6 random: random sample_valid and get_wr_req for 2000 clk against a scoreboard model ->
//   zero mismatches; no pop while empty; fifo_count never exceeds 16.

Source files
------------

// File: rtl/sample_to_wr_req.sv
// Packs 32-bit capture samples into 128-bit DDR2 words, tags each word with a byte address,
// and queues word+address pairs in a first-word-fall-through FIFO for fifo_to_app.
module sample_to_wr_req #(
  parameter int          SAMPLE_W   = 32,
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [26:0] ADX_BASE   = 27'h0000000,
  parameter logic [26:0] ADX_END    = 27'h7FFFFF0,
  parameter logic [26:0] ADX_STEP   = 27'd16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  sample_valid,
  input  logic [SAMPLE_W-1:0]   sample_data,
  output logic                  has_wr_req,
  input  logic                  get_wr_req,
  output logic [127:0]          wr_data_out,
  output logic [26:0]           wr_adx_out,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
  output logic                  wrapped
);

  localparam int LANES  = 128 / SAMPLE_W;
  localparam int LANE_W = $clog2(LANES);
  localparam int DEPTH  = 2 ** DEPTH_LOG2;

  logic [LANE_W-1:0]       lane;
  logic [127-SAMPLE_W:0]   pack;
  logic [DEPTH_LOG2:0]     wptr;
  logic [DEPTH_LOG2:0]     rptr;
  logic [26:0]             adx;
  logic [154:0]            mem [DEPTH];
  logic [127:0]            word;
  logic                    push;
  logic                    pop;
  logic                    accept;
  logic                    full;
  logic                    empty;

  // The last sample goes straight into the top lane, so a word completes in the same cycle.
  assign word   = {sample_data, pack};
  assign empty  = (wptr == rptr);
  assign full   = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                  (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
  assign push   = sample_valid && (lane == LANE_W'(LANES - 1));
  assign pop    = get_wr_req && !empty;
  assign accept = push && (!full || pop);

  assign has_wr_req                = !empty;
  assign {wr_data_out, wr_adx_out} = empty ? '0 : mem[rptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      lane       <= '0;
      pack       <= '0;
      wptr       <= '0;
      rptr       <= '0;
      adx        <= ADX_BASE;
      fifo_count <= '0;
      overflow   <= 1'b0;
      wrapped    <= 1'b0;
    end else begin
      wrapped <= 1'b0;
      if (sample_valid) begin
        lane <= lane + 1'b1;
        if (!push) pack[lane*SAMPLE_W +: SAMPLE_W] <= sample_data;
      end
      if (push && !accept) overflow <= 1'b1;
      // A dropped word leaves the address counter untouched.
      if (accept) begin
        wptr <= wptr + 1'b1;
        if (adx == ADX_END) begin
          adx     <= ADX_BASE;
          wrapped <= 1'b1;
        end else begin
          adx <= adx + ADX_STEP;
        end
      end
      if (pop) rptr <= rptr + 1'b1;
      if (accept && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !accept) fifo_count <= fifo_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wptr[DEPTH_LOG2-1:0]] <= {word, adx};
  end

endmodule

// File: tb/tb_sample_to_wr_req.sv
// Scoreboard bench for sample_to_wr_req: two instances (default end address and a short
// wrap range) share one stimulus stream and one behavioural model of packing and queueing.
module tb_sample_to_wr_req;

  localparam logic [26:0] END_A = 27'h7FFFFF0;
  localparam logic [26:0] END_B = 27'h30;

  typedef struct packed {
    logic [127:0] d;
    logic [26:0]  a;
    logic [26:0]  b;
  } ent_t;

  logic         clk = 1'b0;
  logic         resetn, flush, sample_valid, get_wr_req;
  logic [31:0]  sample_data;
  logic         has_a, has_b, ovf_a, ovf_b, wrap_a, wrap_b;
  logic [127:0] data_a, data_b;
  logic [26:0]  adx_a, adx_b;
  logic [4:0]   cnt_a, cnt_b;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [31:0] parts[$];
  ent_t        exp_q[$];
  int          m_cnt;
  logic [26:0] m_adx_a, m_adx_b;
  logic        m_ovf, m_wrap_a, m_wrap_b;
  logic        clr_pending = 1'b0;

  // Expected values for the cycle currently presented by the DUT
  int          cur_cnt = 0;
  logic        cur_ovf = 1'b0, cur_wrap_a = 1'b0, cur_wrap_b = 1'b0, cur_pop = 1'b0;

  always #5 clk = ~clk;

  sample_to_wr_req dut (
    .clk(clk), .resetn(resetn), .flush(flush), .sample_valid(sample_valid),
    .sample_data(sample_data), .has_wr_req(has_a), .get_wr_req(get_wr_req),
    .wr_data_out(data_a), .wr_adx_out(adx_a), .fifo_count(cnt_a),
    .overflow(ovf_a), .wrapped(wrap_a)
  );

  sample_to_wr_req #(.ADX_END(END_B)) dut_w (
    .clk(clk), .resetn(resetn), .flush(flush), .sample_valid(sample_valid),
    .sample_data(sample_data), .has_wr_req(has_b), .get_wr_req(get_wr_req),
    .wr_data_out(data_b), .wr_adx_out(adx_b), .fifo_count(cnt_b),
    .overflow(ovf_b), .wrapped(wrap_b)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs and advances the model to the state after the coming edge.
  task automatic applyStimulus(input logic rn, input logic fl, input logic sv,
                               input logic [31:0] sd, input logic gt);
    logic pop;
    ent_t e;
    resetn = rn; flush = fl; sample_valid = sv; sample_data = sd; get_wr_req = gt;
    cur_cnt = m_cnt; cur_ovf = m_ovf; cur_wrap_a = m_wrap_a; cur_wrap_b = m_wrap_b;
    pop = rn && !fl && gt && (m_cnt > 0);
    cur_pop = pop;
    if (!rn || fl) begin
      parts.delete();
      m_cnt = 0; m_adx_a = '0; m_adx_b = '0;
      m_ovf = 1'b0; m_wrap_a = 1'b0; m_wrap_b = 1'b0;
      clr_pending = 1'b1;
    end else begin
      m_wrap_a = 1'b0; m_wrap_b = 1'b0;
      if (sv) begin
        parts.push_back(sd);
        if (parts.size() == 4) begin
          e.d = {parts[3], parts[2], parts[1], parts[0]};
          parts.delete();
          if (m_cnt < 16 || pop) begin
            e.a = m_adx_a; e.b = m_adx_b;
            exp_q.push_back(e);
            m_wrap_a = (m_adx_a == END_A);
            m_wrap_b = (m_adx_b == END_B);
            m_adx_a = m_wrap_a ? 27'd0 : m_adx_a + 27'd16;
            m_adx_b = m_wrap_b ? 27'd0 : m_adx_b + 27'd16;
            m_cnt++;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
      if (pop) m_cnt--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sendSamples(input int n, input logic [31:0] start, input logic gt);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b1, start + 32'(i), gt);
  endtask

  task automatic idle(input int n, input logic gt);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, $urandom, gt);
  endtask

  // Monitor: compares outputs mid-cycle and retires the head entry on each handshake.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      checkOutput("has_wr_req", 128'(has_a), 128'(cur_cnt != 0));
      checkOutput("has_wr_req_w", 128'(has_b), 128'(cur_cnt != 0));
      checkOutput("fifo_count", 128'(cnt_a), 128'(cur_cnt));
      checkOutput("fifo_count_w", 128'(cnt_b), 128'(cur_cnt));
      checkOutput("overflow", 128'(ovf_a), 128'(cur_ovf));
      checkOutput("overflow_w", 128'(ovf_b), 128'(cur_ovf));
      checkOutput("wrapped", 128'(wrap_a), 128'(cur_wrap_a));
      checkOutput("wrapped_w", 128'(wrap_b), 128'(cur_wrap_b));
      if (cur_cnt != 0) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL scoreboard: got empty queue expected %0d entries at %0t", cur_cnt, $time);
        end else begin
          checkOutput("wr_data_out", data_a, exp_q[0].d);
          checkOutput("wr_adx_out", 128'(adx_a), 128'(exp_q[0].a));
          checkOutput("wr_data_out_w", data_b, exp_q[0].d);
          checkOutput("wr_adx_out_w", 128'(adx_b), 128'(exp_q[0].b));
          if (cur_pop) void'(exp_q.pop_front());
        end
      end
      if (clr_pending) begin
        exp_q.delete();
        clr_pending = 1'b0;
      end
    end
  end

  initial begin
    int gp;
    m_cnt = 0; m_adx_a = '0; m_adx_b = '0;
    m_ovf = 1'b0; m_wrap_a = 1'b0; m_wrap_b = 1'b0;

    $display("[TB] reset with sample_valid high");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, $urandom, 1'b0);
    idle(1, 1'b0);

    $display("[TB] packing two words");
    sendSamples(4, 32'd1, 1'b0);
    idle(1, 1'b0);
    sendSamples(4, 32'd5, 1'b0);
    idle(2, 1'b0);
    idle(3, 1'b1);

    $display("[TB] backpressure and overflow");
    for (int i = 0; i < 68; i++) applyStimulus(1'b1, 1'b0, 1'b1, $urandom, 1'b0);
    idle(2, 1'b0);
    sendSamples(3, 32'hA0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hA3, 1'b1);
    idle(18, 1'b1);
    sendSamples(4, 32'hB0, 1'b0);
    idle(2, 1'b1);

    $display("[TB] address wrap");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b1, $urandom, 1'b1);
    idle(3, 1'b1);

    $display("[TB] mid-operation flush");
    sendSamples(2, 32'hC0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hDEAD, 1'b1);
    sendSamples(4, 32'hD0, 1'b0);
    idle(2, 1'b0);
    idle(2, 1'b1);

    $display("[TB] random traffic");
    gp = 50;
    for (int c = 0; c < 2000; c++) begin
      if (c % 200 == 0) begin
        case ((c / 200) % 3)
          0:       gp = 10;
          1:       gp = 90;
          default: gp = 50;
        endcase
      end
      applyStimulus(1'b1, $urandom_range(0, 299) == 0, $urandom_range(0, 99) < 70,
                    $urandom, $urandom_range(0, 99) < gp);
    end
    idle(20, 1'b1);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
